// File: rtl/axi4_lite_default_slave.sv
// AXI4-lite default/error slave. Terminates every transaction on an unmapped
// decode region with a programmable response code and fixed read data.
// AW and W are accepted independently and paired into a B response queue;
// AR goes straight into an R response queue. Both queues are DEPTH deep.
// Optional logging of terminated transactions: AXI4_LITE_DEFAULT_SLAVE_LOG_EN.
module axi4_lite_default_slave #(
  parameter int          A     = 32,
  parameter int          N     = 4,
  parameter int          I     = 4,
  parameter logic [63:0] D     = 64'hbaadc0de,
  parameter logic [1:0]  RESP  = 2'b11,
  parameter int          DEPTH = 4,
  localparam int         IW    = (I > 0) ? I : 1,
  localparam int         DW    = 8 * N
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          awvalid,
  output logic          awready,
  input  logic [A-1:0]  awaddr,
  input  logic [2:0]    awprot,
  input  logic [IW-1:0] awid,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  input  logic [N-1:0]  wstrb,
  output logic          bvalid,
  input  logic          bready,
  output logic [1:0]    bresp,
  output logic [IW-1:0] bid,
  input  logic          arvalid,
  output logic          arready,
  input  logic [A-1:0]  araddr,
  input  logic [2:0]    arprot,
  input  logic [IW-1:0] arid,
  output logic          rvalid,
  input  logic          rready,
  output logic [DW-1:0] rdata,
  output logic [1:0]    rresp,
  output logic [IW-1:0] rid,
  output logic [31:0]   err_count,
  output logic [A-1:0]  err_addr,
  output logic          err_valid
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          areset_q;
  logic          aw_held, w_held;
  logic          aw_hs, w_hs;
  logic          b_full, b_push, b_pop;
  logic          r_full, r_push, r_pop;
  logic [CW-1:0] b_count, r_count;
  logic          unused_inputs;

  // Payload the slave never looks at.
  assign unused_inputs = ^{wdata, wstrb, awprot, arprot, awaddr, araddr, awid, arid};

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign awready = ~aw_held & ~areset_q;
  assign wready  = ~w_held & ~areset_q;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  assign b_full  = (b_count == CW'(DEPTH));
  assign b_push  = aw_held & w_held & ~b_full;
  assign bvalid  = (b_count != '0);
  assign b_pop   = bvalid & bready;
  assign bresp   = RESP;

  // Full is taken from the registered count, so a pop never frees a slot in the same cycle.
  assign r_full  = (r_count == CW'(DEPTH));
  assign arready = ~r_full & ~areset_q;
  assign r_push  = arvalid & arready;
  assign rvalid  = (r_count != '0);
  assign r_pop   = rvalid & rready;
  assign rdata   = DW'(D);
  assign rresp   = RESP;

  // Delayed reset keeps readies low for one cycle after release.
  always_ff @(posedge aclk) begin
    areset_q <= areset;
  end

  // AW/W hold flags; both clear together when the pair enters the B queue.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else if (b_push) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
    end
  end

  // Occupancy counters for both response queues.
  always_ff @(posedge aclk) begin
    if (areset) begin
      b_count <= '0;
      r_count <= '0;
    end else begin
      case ({b_push, b_pop})
        2'b10:   b_count <= b_count + CW'(1);
        2'b01:   b_count <= b_count - CW'(1);
        default: b_count <= b_count;
      endcase
      case ({r_push, r_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    if (I > 0) begin : g_ids
      logic [IW-1:0] awid_q;
      logic [IW-1:0] b_mem [0:(1<<PW)-1];
      logic [IW-1:0] r_mem [0:(1<<PW)-1];
      logic [PW-1:0] b_wptr, b_rptr, r_wptr, r_rptr;

      // Queue pointers wrap modulo DEPTH.
      always_ff @(posedge aclk) begin
        if (areset) begin
          b_wptr <= '0;
          b_rptr <= '0;
          r_wptr <= '0;
          r_rptr <= '0;
        end else begin
          if (b_push) b_wptr <= ptr_inc(b_wptr);
          if (b_pop)  b_rptr <= ptr_inc(b_rptr);
          if (r_push) r_wptr <= ptr_inc(r_wptr);
          if (r_pop)  r_rptr <= ptr_inc(r_rptr);
        end
      end

      // ID storage: held awid and the two queue bodies.
      always_ff @(posedge aclk) begin
        if (aw_hs)  awid_q         <= awid;
        if (b_push) b_mem[b_wptr] <= awid_q;
        if (r_push) r_mem[r_wptr] <= arid;
      end

      assign bid = b_mem[b_rptr];
      assign rid = r_mem[r_rptr];
    end else begin : g_no_ids
      assign bid = '0;
      assign rid = '0;
    end
  endgenerate

`ifdef AXI4_LITE_DEFAULT_SLAVE_LOG_EN
  logic [A-1:0] awaddr_q;
  logic [32:0]  err_sum;

  assign err_sum = {1'b0, err_count} + 33'(b_push) + 33'(r_push);

  // Address of the write currently held for pairing.
  always_ff @(posedge aclk) begin
    if (aw_hs) awaddr_q <= awaddr;
  end

  // Saturating count of terminated transactions and first-address capture; reads win ties.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_count <= '0;
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else begin
      err_count <= err_sum[32] ? 32'hffff_ffff : err_sum[31:0];
      if (~err_valid & (b_push | r_push)) begin
        err_valid <= 1'b1;
        err_addr  <= r_push ? araddr : awaddr_q;
      end
    end
  end
`else
  assign err_count = '0;
  assign err_addr  = '0;
  assign err_valid = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_lite_default_slave.sv
// Bench for axi4_lite_default_slave: directed scenarios plus random traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_axi4_lite_default_slave;
  localparam int A = 32, N = 4, I = 4, DEPTH = 4, DW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [A-1:0]  awaddr = '0, araddr = '0;
  logic [2:0]    awprot = '0, arprot = '0;
  logic [I-1:0]  awid = '0, arid = '0;
  logic [DW-1:0] wdata = '0;
  logic [N-1:0]  wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, err_valid;
  logic [1:0]    bresp, rresp;
  logic [I-1:0]  bid, rid;
  logic [DW-1:0] rdata;
  logic [31:0]   err_count;
  logic [A-1:0]  err_addr;

  int tests = 0, fails = 0;

  axi4_lite_default_slave #(.A(A), .N(N), .I(I), .DEPTH(DEPTH)) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid),
    .err_count(err_count), .err_addr(err_addr), .err_valid(err_valid)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit           live = 0;
  bit           m_rst_q, m_aw_held, m_w_held, m_evalid;
  logic [I-1:0] m_awid;
  logic [A-1:0] m_awaddr, m_eaddr;
  logic [I-1:0] m_bq[$], m_rq[$];
  longint       m_cnt;

  always @(posedge aclk) begin
    bit aw_hs, w_hs, ar_hs, b_push;
    int n;
    if (areset) begin
      m_rst_q = 1; m_aw_held = 0; m_w_held = 0; m_evalid = 0;
      m_bq.delete(); m_rq.delete(); m_cnt = 0; m_eaddr = '0;
      live = 1;
    end else if (live) begin
      aw_hs  = awvalid && !m_aw_held && !m_rst_q;
      w_hs   = wvalid && !m_w_held && !m_rst_q;
      ar_hs  = arvalid && (m_rq.size() < DEPTH) && !m_rst_q;
      b_push = m_aw_held && m_w_held && (m_bq.size() < DEPTH);
      if (m_bq.size() > 0 && bready) void'(m_bq.pop_front());
      if (m_rq.size() > 0 && rready) void'(m_rq.pop_front());
      n = int'(b_push) + int'(ar_hs);
      m_cnt = m_cnt + n;
      if (m_cnt > 64'hffff_ffff) m_cnt = 64'hffff_ffff;
      if (n > 0 && !m_evalid) begin
        m_evalid = 1;
        m_eaddr  = ar_hs ? araddr : m_awaddr;
      end
      if (b_push) begin
        m_bq.push_back(m_awid);
        m_aw_held = 0; m_w_held = 0;
      end
      if (ar_hs) m_rq.push_back(arid);
      if (aw_hs) begin m_aw_held = 1; m_awid = awid; m_awaddr = awaddr; end
      if (w_hs) m_w_held = 1;
      m_rst_q = 0;
    end
  end

  // Per-cycle compare of every meaningful output against the model.
  always @(negedge aclk) begin
    if (live) begin
      check("awready", awready, !m_aw_held && !m_rst_q);
      check("wready",  wready,  !m_w_held && !m_rst_q);
      check("arready", arready, (m_rq.size() < DEPTH) && !m_rst_q);
      check("bvalid",  bvalid,  m_bq.size() > 0);
      check("rvalid",  rvalid,  m_rq.size() > 0);
      if (m_bq.size() > 0) begin
        check("bid", bid, m_bq[0]);
        check("bresp", bresp, 2'b11);
      end
      if (m_rq.size() > 0) begin
        check("rid", rid, m_rq[0]);
        check("rdata", rdata, 32'hbaadc0de);
        check("rresp", rresp, 2'b11);
      end
`ifdef AXI4_LITE_DEFAULT_SLAVE_LOG_EN
      check("err_count", err_count, m_cnt);
      check("err_valid", err_valid, m_evalid);
      if (m_evalid) check("err_addr", err_addr, m_eaddr);
`else
      check("err_count", err_count, 0);
      check("err_valid", err_valid, 0);
      check("err_addr", err_addr, 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [I-1:0] id, input logic [A-1:0] addr);
    awvalid = 1; wvalid = 1; awid = id; awaddr = addr;
    step();
    awvalid = 0; wvalid = 0;
    repeat (3) step();
  endtask

  initial begin
    int id, nb, k, cyc;
    logic [I-1:0] got[$];

    // Reset: readies stay low in the release cycle, rise one cycle later.
    step();
    areset = 0;
    check("rst_awready", awready, 0);
    check("rst_wready",  wready,  0);
    check("rst_arready", arready, 0);
    check("rst_bvalid",  bvalid,  0);
    check("rst_rvalid",  rvalid,  0);
    step();
    check("rel_awready", awready, 1);
    check("rel_arready", arready, 1);

    // Single write, AW and W together: bvalid two cycles later for one cycle.
    bready = 1;
    awvalid = 1; wvalid = 1; awid = 3; awaddr = 32'h1000;
    step();
    awvalid = 0; wvalid = 0;
    check("wr1_bvalid_t1", bvalid, 0);
    step();
    check("wr1_bvalid_t2", bvalid, 1);
    check("wr1_bid", bid, 3);
    check("wr1_bresp", bresp, 2'b11);
    step();
    check("wr1_bvalid_t3", bvalid, 0);

    // W three cycles ahead of AW.
    wvalid = 1;
    step();
    wvalid = 0;
    check("wfirst_wready", wready, 0);
    step(); step();
    awvalid = 1; awid = 5; awaddr = 32'h2000;
    step();
    awvalid = 0;
    check("wfirst_bvalid_t1", bvalid, 0);
    step();
    check("wfirst_bvalid_t2", bvalid, 1);
    check("wfirst_bid", bid, 5);
    step();

    // Third write then two reads: five terminated transactions.
    do_write(4'h7, 32'h3000);
    rready = 1; arvalid = 1; araddr = 32'h4000; arid = 1;
    step();
    arid = 2;
    step();
    arvalid = 0;
    repeat (3) step();
`ifdef AXI4_LITE_DEFAULT_SLAVE_LOG_EN
    check("log_count", err_count, 5);
    check("log_addr",  err_addr,  32'h1000);
    check("log_valid", err_valid, 1);
`else
    check("log_count", err_count, 0);
    check("log_addr",  err_addr,  0);
    check("log_valid", err_valid, 0);
`endif

    // B queue full: 4 queued plus 1 held, then drain in order.
    bready = 0; id = 0;
    for (cyc = 0; cyc < 30; cyc++) begin
      awvalid = (id < 6); wvalid = (id < 6); awid = I'(id);
      if (awvalid && awready && wready) id++;
      step();
    end
    awvalid = 0; wvalid = 0;
    check("full_accepted", id, 5);
    check("full_awready", awready, 0);
    check("full_wready",  wready,  0);
    check("full_bvalid",  bvalid,  1);
    bready = 1; got.delete();
    for (cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      awvalid = (id < 6); wvalid = (id < 6); awid = I'(id);
      if (bvalid) got.push_back(bid);
      if (awvalid && awready && wready) id++;
      step();
    end
    awvalid = 0; wvalid = 0;
    check("full_sixth_accepted", id, 6);
    check("full_beats", got.size(), 6);
    for (int j = 0; j < 6; j++) check("full_order", (j < got.size()) ? got[j] : 4'hx, I'(j));
    repeat (3) step();

    // Eight back-to-back reads at one per cycle.
    rready = 1; k = 0; nb = 0; got.delete();
    for (cyc = 0; cyc < 40 && got.size() < 8; cyc++) begin
      arvalid = (k < 8); arid = I'(k); araddr = 32'h5000 + 32'(k);
      if (rvalid) begin
        got.push_back(rid);
        check("rd8_rdata", rdata, 32'hbaadc0de);
      end
      if (arvalid && arready) begin k++; if (k == 8) nb = cyc + 1; end
      step();
    end
    arvalid = 0;
    check("rd8_cycles", nb, 8);
    check("rd8_beats", got.size(), 8);
    for (int j = 0; j < 8; j++) check("rd8_order", (j < got.size()) ? got[j] : 4'hx, I'(j));

    // Reset with reads outstanding discards them.
    rready = 0; arvalid = 1; arid = 9;
    step();
    arid = 10;
    step();
    arvalid = 0;
    check("rstmid_rvalid_before", rvalid, 1);
    areset = 1;
    step();
    areset = 0;
    check("rstmid_rvalid", rvalid, 0);
    check("rstmid_arready", arready, 0);
    step();
    check("rstmid_arready_back", arready, 1);
    rready = 1;
    repeat (3) begin
      step();
      check("rstmid_no_stale", rvalid, 0);
    end

    // Random traffic against the model.
    for (cyc = 0; cyc < 3000; cyc++) begin
      areset  = ($urandom_range(0, 299) == 0);
      awvalid = $urandom_range(0, 1);
      wvalid  = $urandom_range(0, 1);
      arvalid = $urandom_range(0, 1);
      bready  = ($urandom_range(0, 3) != 0);
      rready  = ($urandom_range(0, 3) != 0);
      awid    = I'($urandom);
      arid    = I'($urandom);
      awaddr  = $urandom;
      araddr  = $urandom;
      wdata   = $urandom;
      wstrb   = N'($urandom);
      step();
    end
    areset = 0; awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
